// File: rtl/mac_unit.sv
// mac_unit: sequential signed multiply-accumulate core.
// Each accepted start multiplies two OPSIZE-bit two's-complement operands.
// The multiplier is an iterative shift-add unit that does one step per clock.
// The full 2*OPSIZE-bit product is then added into a wrapping accumulator.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | ready high; a start on the next edge latches a/b
//   S_MUL  | OPSIZE shift-add steps, one per edge; out is held
//   S_ACC  | single edge: out <= out + product, ready returns high
module mac_unit #(
    parameter int OPSIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [OPSIZE-1:0]     a,
    input  logic [OPSIZE-1:0]     b,
    output logic [2*OPSIZE-1:0]   out,
    output logic                  ready
);

    localparam int W  = 2 * OPSIZE;
    localparam int CW = $clog2(OPSIZE + 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(OPSIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_mcand;     // sign-extended multiplicand, shifted left each step
    logic [OPSIZE-1:0] r_mplier;    // multiplier, shifted right each step
    logic [W-1:0]      r_partial;
    logic [CW-1:0]     r_step;
    logic [W-1:0]      r_acc;
    logic              r_ready;

    logic              w_last;
    logic [W-1:0]      w_addend;
    logic [W-1:0]      w_partial_next;

    // The multiplier's top bit carries weight -2^(OPSIZE-1) in two's complement.
    // On the final step the shifted multiplicand is therefore subtracted.
    // This keeps the product exact, including for the most-negative squared.
    always_comb begin
        w_last         = (r_step == STEP_LAST);
        w_addend       = w_last ? (~r_mcand + 1'b1) : r_mcand;
        w_partial_next = r_mplier[0] ? (r_partial + w_addend) : r_partial;
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_partial <= '0;
            r_step    <= '0;
            r_acc     <= '0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand   <= {{OPSIZE{a[OPSIZE-1]}}, a};
                        r_mplier  <= b;
                        r_partial <= '0;
                        r_step    <= '0;
                        r_ready   <= 1'b0;
                        r_state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_partial <= w_partial_next;
                    r_mcand   <= r_mcand << 1;
                    r_mplier  <= r_mplier >> 1;
                    r_step    <= r_step + 1'b1;
                    if (w_last) begin
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc   <= r_acc + r_partial;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out   = r_acc;
    assign ready = r_ready;

endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: directed tests for the sequential signed MAC core.
module tb_mac_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] out;
    logic        ready;

    int errors;
    int checks;

    mac_unit #(.OPSIZE(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .out   (out),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: issue one start pulse and count the negedges that show ready low.
    // Also note whether out moved during that window. Results go to the caller's checks.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          output int lowcnt, output bit hold_ok);
        logic [31:0] prev;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prev = out;
        lowcnt = 0;
        hold_ok = 1'b1;
        while (ready == 1'b0 && lowcnt < 40) begin
            lowcnt++;
            if (out !== prev) hold_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // reset asserted together with start at time zero
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out !== 32'h0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold: out=%h ready=%b, need out=00000000 ready=1", out, ready);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int  lc;
        bit  hk;
        run_op(16'd3, 16'd5, lc, hk);
        checks++;
        if (out !== 32'd15) begin
            errors++;
            $display("FAIL pre_reset_op: out=%h need 0000000f", out);
        end
        @(negedge clk);
        a = 16'd1; b = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_before_reset: ready=%b need 0", ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 32'h0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: out=%h ready=%b, need out=00000000 ready=1", out, ready);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(16'd2, 16'd3, lc, hk);
        checks++;
        if (lc !== 17 || out !== 32'd6) begin
            errors++;
            $display("FAIL after_reset_op: lowcnt=%0d out=%h, need 17 and 00000006", lc, out);
        end
    endtask

    task automatic test_signed_mul();
        int lc;
        bit hk;
        apply_reset();
        run_op(16'h7FFF, 16'h251E, lc, hk);
        checks++;
        if (lc !== 17) begin
            errors++;
            $display("FAIL latency: ready low %0d cycles, need 17", lc);
        end
        checks++;
        if (!hk) begin
            errors++;
            $display("FAIL out_hold: out moved during MUL (hold_ok=%b, need 1)", hk);
        end
        checks++;
        if (out !== 32'h128EDAE2) begin
            errors++;
            $display("FAIL pos_product: out=%h need 128edae2", out);
        end
        checks++;
        if (out[30:15] !== 16'h251D) begin
            errors++;
            $display("FAIL q15_slice: out[30:15]=%h need 251d", out[30:15]);
        end
        run_op(16'h7FFF, 16'hB508, lc, hk);
        checks++;
        if (out !== 32'hED1325DA || lc !== 17) begin
            errors++;
            $display("FAIL neg_accum: out=%h lowcnt=%0d, need ed1325da and 17", out, lc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v [4];
        int lc;
        exp_v[0] = 32'h40000000;
        exp_v[1] = 32'h80000000;
        exp_v[2] = 32'hC0000000;
        exp_v[3] = 32'h00000000;
        apply_reset();
        @(negedge clk);
        a = 16'h8000; b = 16'h8000; start = 1'b1;
        for (int op = 0; op < 4; op++) begin
            if (op == 0) @(negedge clk);
            lc = 0;
            while (ready == 1'b0 && lc < 40) begin
                lc++;
                @(negedge clk);
            end
            checks++;
            if (lc !== 17 || out !== exp_v[op]) begin
                errors++;
                $display("FAIL b2b_op%0d: lowcnt=%0d out=%h, need 17 and %h", op, lc, out, exp_v[op]);
            end
            if (op == 3) start = 1'b0;
            @(negedge clk);
            checks++;
            if (ready !== (op == 3)) begin
                errors++;
                $display("FAIL b2b_gap%0d: ready=%b need %b", op, ready, (op == 3));
            end
        end
    endtask

    task automatic test_busy_start();
        int k;
        apply_reset();
        @(negedge clk);
        a = 16'd3; b = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (ready == 1'b0 && k < 40) begin
            k++;
            if (k == 2) begin a = 16'd7; b = 16'd9; end
            if (k == 4) start = 1'b1;
            if (k == 5) start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (k !== 17 || out !== 32'd15) begin
            errors++;
            $display("FAIL busy_start: lowcnt=%0d out=%h, need 17 and 0000000f", k, out);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || out !== 32'd15) begin
            errors++;
            $display("FAIL no_queued_op: ready=%b out=%h, need 1 and 0000000f", ready, out);
        end
    endtask

    task automatic test_zero_and_minus_one();
        int lc;
        bit hk;
        apply_reset();
        run_op(16'h0000, 16'h1234, lc, hk);
        checks++;
        if (out !== 32'h0 || lc !== 17) begin
            errors++;
            $display("FAIL zero_a: out=%h lowcnt=%0d, need 00000000 and 17", out, lc);
        end
        run_op(16'h5678, 16'h0000, lc, hk);
        checks++;
        if (out !== 32'h0) begin
            errors++;
            $display("FAIL zero_b: out=%h need 00000000", out);
        end
        run_op(16'hFFFF, 16'h0001, lc, hk);
        checks++;
        if (out !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL minus_one: out=%h need ffffffff", out);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b1;
        a      = 16'h1111;
        b      = 16'h2222;
        test_reset();
        test_reset_mid();
        test_signed_mul();
        test_back_to_back();
        test_busy_start();
        test_zero_and_minus_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
